vga_sync_zybo: RTL and testbench



---
 rtl/vga_sync_zybo.sv | 141 ++++++++++++++
 tb/tb_vga_sync_zybo.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_zybo.sv
// 640x480@60 VGA timing for the Zybo: pixel counters, blanking, sync decode and a
// matched output pipeline. Optional colour-bar generator under VGA_TEST_PATTERN_EN.
module vga_sync_zybo #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE     = 2
) (
  input  logic        clk25,
  input  logic        Reset,
  input  logic [4:0]  red_in,
  input  logic [5:0]  green_in,
  input  logic [4:0]  blue_in,
  input  logic        test_pat,
  output logic [9:0]  xpos,
  output logic [9:0]  ypos,
  output logic [4:0]  vga_r,
  output logic [5:0]  vga_g,
  output logic [4:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_tick,
  output logic [15:0] frame_count
);

  localparam logic [9:0] H_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0] V_PRETICK = 10'(V_ACTIVE - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [17:0] BLANK    = {5'd0, 6'd0, 5'd0, 1'b1, 1'b1};

  logic [9:0]  r_xpos;
  logic [9:0]  r_ypos;
  logic        r_frameTick;
  logic [15:0] r_frameCount;
  logic [17:0] r_pipe [PIPE];

  logic        w_active;
  logic        w_hsRaw;
  logic        w_vsRaw;
  logic [4:0]  w_srcR;
  logic [5:0]  w_srcG;
  logic [4:0]  w_srcB;
  logic [17:0] w_stage0;

  always_ff @(posedge clk25) begin
    if (Reset) begin
      r_xpos <= '0;
      r_ypos <= '0;
    end else if (r_xpos == H_LAST) begin
      r_xpos <= '0;
      r_ypos <= (r_ypos == V_LAST) ? 10'd0 : r_ypos + 10'd1;
    end else begin
      r_xpos <= r_xpos + 10'd1;
    end
  end

  // Tick is registered one cycle early so it lands exactly on (0, V_ACTIVE).
  always_ff @(posedge clk25) begin
    if (Reset) begin
      r_frameTick  <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_frameTick <= (r_xpos == H_LAST) && (r_ypos == V_PRETICK);
      if (r_frameTick) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
    end
  end

  assign w_active = (r_xpos < H_ACT) && (r_ypos < V_ACT);
  assign w_hsRaw  = !((r_xpos >= HS_START) && (r_xpos < HS_END));
  assign w_vsRaw  = !((r_ypos >= VS_START) && (r_ypos < VS_END));

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);
  logic [9:0] w_barIdx;
  logic [2:0] w_barRgb;

  assign w_barIdx = r_xpos / BAR_W;

  // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    w_barRgb = 3'b000;
    case (w_barIdx)
      10'd0:   w_barRgb = 3'b111;
      10'd1:   w_barRgb = 3'b110;
      10'd2:   w_barRgb = 3'b011;
      10'd3:   w_barRgb = 3'b010;
      10'd4:   w_barRgb = 3'b101;
      10'd5:   w_barRgb = 3'b100;
      10'd6:   w_barRgb = 3'b001;
      default: w_barRgb = 3'b000;
    endcase
  end

  assign w_srcR = test_pat ? {5{w_barRgb[2]}} : red_in;
  assign w_srcG = test_pat ? {6{w_barRgb[1]}} : green_in;
  assign w_srcB = test_pat ? {5{w_barRgb[0]}} : blue_in;
`else
  logic w_unusedTestPat;
  assign w_unusedTestPat = test_pat;
  assign w_srcR = red_in;
  assign w_srcG = green_in;
  assign w_srcB = blue_in;
`endif

  assign w_stage0 = w_active ? {w_srcR, w_srcG, w_srcB, w_hsRaw, w_vsRaw}
                             : {16'd0, w_hsRaw, w_vsRaw};

  // Colour and both syncs share one chain so they can never skew.
  always_ff @(posedge clk25) begin
    if (Reset) begin
      for (int i = 0; i < PIPE; i++) begin
        r_pipe[i] <= BLANK;
      end
    end else begin
      r_pipe[0] <= w_stage0;
      for (int i = 1; i < PIPE; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign xpos        = r_xpos;
  assign ypos        = r_ypos;
  assign frame_tick  = r_frameTick;
  assign frame_count = r_frameCount;
  assign {vga_r, vga_g, vga_b, vga_hs, vga_vs} = r_pipe[PIPE-1];

endmodule

// File: tb/tb_vga_sync_zybo.sv
// Self-checking bench for vga_sync_zybo, run with shrunken timing so whole
// frames fit in a short simulation. A model pushes expected pin values per cycle.
`timescale 1ns/1ps
module tb_vga_sync_zybo;

  localparam int TB_HA    = 40;
  localparam int TB_HFP   = 4;
  localparam int TB_HS    = 6;
  localparam int TB_HBP   = 6;
  localparam int TB_VA    = 20;
  localparam int TB_VFP   = 3;
  localparam int TB_VS    = 2;
  localparam int TB_VBP   = 4;
  localparam int TB_PIPE  = 2;
  localparam int TB_HT    = TB_HA + TB_HFP + TB_HS + TB_HBP;
  localparam int TB_VT    = TB_VA + TB_VFP + TB_VS + TB_VBP;
  localparam int TB_FRAME = TB_HT * TB_VT;

  typedef logic [17:0] pins_t;

  logic        clk25 = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  red_in = '0;
  logic [5:0]  green_in = '0;
  logic [4:0]  blue_in = '0;
  logic        test_pat = 1'b0;
  logic [9:0]  xpos;
  logic [9:0]  ypos;
  logic [4:0]  vga_r;
  logic [5:0]  vga_g;
  logic [4:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        frame_tick;
  logic [15:0] frame_count;

  int          total = 0;
  int          bad = 0;
  int          mx = 0;
  int          my = 0;
  logic [15:0] mCount = '0;
  pins_t       sbq[$];

  vga_sync_zybo #(
    .H_ACTIVE(TB_HA), .H_FP(TB_HFP), .H_SYNC(TB_HS), .H_BP(TB_HBP),
    .V_ACTIVE(TB_VA), .V_FP(TB_VFP), .V_SYNC(TB_VS), .V_BP(TB_VBP),
    .PIPE(TB_PIPE)
  ) dut (
    .clk25(clk25), .Reset(Reset),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .test_pat(test_pat),
    .xpos(xpos), .ypos(ypos),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .frame_tick(frame_tick), .frame_count(frame_count)
  );

  always #20 clk25 = ~clk25;

  function automatic pins_t blankPins();
    return {5'd0, 6'd0, 5'd0, 1'b1, 1'b1};
  endfunction

  // Reference behaviour of the pins for one pixel, straight from the timing description.
  function automatic pins_t modelPins(int x, int y, logic tp,
                                      logic [4:0] r, logic [5:0] g, logic [4:0] b);
    logic [4:0] cr;
    logic [5:0] cg;
    logic [4:0] cb;
    logic       hs;
    logic       vs;
    cr = r;
    cg = g;
    cb = b;
`ifdef VGA_TEST_PATTERN_EN
    if (tp) begin
      case (x / (TB_HA / 8))
        0:       {cr, cg, cb} = {5'h1F, 6'h3F, 5'h1F};
        1:       {cr, cg, cb} = {5'h1F, 6'h3F, 5'h00};
        2:       {cr, cg, cb} = {5'h00, 6'h3F, 5'h1F};
        3:       {cr, cg, cb} = {5'h00, 6'h3F, 5'h00};
        4:       {cr, cg, cb} = {5'h1F, 6'h00, 5'h1F};
        5:       {cr, cg, cb} = {5'h1F, 6'h00, 5'h00};
        6:       {cr, cg, cb} = {5'h00, 6'h00, 5'h1F};
        default: {cr, cg, cb} = 16'd0;
      endcase
    end
`else
    if (tp === 1'bz) cr = r;
`endif
    if (!(x < TB_HA && y < TB_VA)) begin
      cr = '0;
      cg = '0;
      cb = '0;
    end
    hs = !(x >= TB_HA + TB_HFP && x < TB_HA + TB_HFP + TB_HS);
    vs = !(y >= TB_VA + TB_VFP && y < TB_VA + TB_VFP + TB_VS);
    return {cr, cg, cb, hs, vs};
  endfunction

  // One clock: queue the expectation for the pixel being presented now, retire the
  // entry the pins have just finished showing, then advance the model counters.
  task automatic advance();
    logic  wasReset;
    logic  tickNow;
    pins_t e;
    wasReset = Reset;
    tickNow  = (mx == 0 && my == TB_VA);
    e = modelPins(mx, my, test_pat, red_in, green_in, blue_in);
    sbq.push_back(e);
    void'(sbq.pop_front());
    @(posedge clk25);
    #1;
    if (wasReset) begin
      mx = 0;
      my = 0;
      mCount = '0;
      sbq.delete();
      for (int i = 0; i < TB_PIPE; i++) sbq.push_back(blankPins());
    end else begin
      if (tickNow) mCount = mCount + 16'd1;
      if (mx == TB_HT - 1) begin
        mx = 0;
        my = (my == TB_VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
  endtask

  task automatic test_reset();
    red_in = 5'h1F;
    green_in = 6'h2A;
    blue_in = 5'h15;
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) advance();
    Reset = 1'b0;
    total++;
    if (xpos !== 10'd0 || ypos !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset_pos got=(%0d,%0d) exp=(0,0)", xpos, ypos);
    end
    total++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== blankPins() || frame_count !== 16'd0 || frame_tick !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_blank0 got=%h cnt=%0d tick=%b exp=%h cnt=0 tick=0",
               {vga_r, vga_g, vga_b, vga_hs, vga_vs}, frame_count, frame_tick, blankPins());
    end
    advance();
    total++;
    if (xpos !== 10'd1 || ypos !== 10'd0) begin
      bad++;
      $display("[TB] FAIL reset_step got=(%0d,%0d) exp=(1,0)", xpos, ypos);
    end
    total++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== blankPins()) begin
      bad++;
      $display("[TB] FAIL reset_blank1 got=%h exp=%h", {vga_r, vga_g, vga_b, vga_hs, vga_vs}, blankPins());
    end
    advance();
    total++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== {5'h1F, 6'h2A, 5'h15, 1'b1, 1'b1}) begin
      bad++;
      $display("[TB] FAIL reset_first_pixel got=%h exp=%h", {vga_r, vga_g, vga_b, vga_hs, vga_vs},
               {5'h1F, 6'h2A, 5'h15, 1'b1, 1'b1});
    end
  endtask

  task automatic test_frame();
    int ticks = 0;
    int t1 = 0;
    int period = 0;
    for (int c = 0; c < 3 * TB_FRAME && ticks < 2; c++) begin
      advance();
      total++;
      if (frame_tick !== (mx == 0 && my == TB_VA)) begin
        bad++;
        $display("[TB] FAIL tick at (%0d,%0d) got=%b", mx, my, frame_tick);
      end
      if (frame_tick === 1'b1) begin
        ticks++;
        total++;
        if (xpos !== 10'd0 || ypos !== 10'(TB_VA)) begin
          bad++;
          $display("[TB] FAIL tick_pos got=(%0d,%0d) exp=(0,%0d)", xpos, ypos, TB_VA);
        end
        total++;
        if (frame_count !== 16'(ticks - 1)) begin
          bad++;
          $display("[TB] FAIL count_at_tick got=%0d exp=%0d", frame_count, ticks - 1);
        end
        if (ticks == 1) t1 = c;
        else period = c - t1;
      end
    end
    total++;
    if (ticks != 2) begin
      bad++;
      $display("[TB] FAIL tick_timeout got=%0d ticks exp=2", ticks);
    end
    total++;
    if (period != TB_FRAME) begin
      bad++;
      $display("[TB] FAIL frame_period got=%0d exp=%0d", period, TB_FRAME);
    end
    advance();
    total++;
    if (frame_count !== 16'd2) begin
      bad++;
      $display("[TB] FAIL count_after_two got=%0d exp=2", frame_count);
    end
  endtask

  task automatic test_colour();
    red_in = 5'h1F;
    for (int c = 0; c < TB_FRAME + 5; c++) begin
      green_in = 6'($urandom);
      blue_in = 5'($urandom);
      advance();
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== sbq[0]) begin
        bad++;
        $display("[TB] FAIL pins at (%0d,%0d) got=%h exp=%h", mx, my,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs}, sbq[0]);
      end
      total++;
      if (xpos !== 10'(mx) || ypos !== 10'(my) || frame_count !== mCount) begin
        bad++;
        $display("[TB] FAIL counters got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                 xpos, ypos, frame_count, mx, my, mCount);
      end
    end
  endtask

  task automatic test_sync();
    logic prevHs = vga_hs;
    logic prevVs = vga_vs;
    int   hsLen = -1;
    int   vsLen = -1;
    int   hsSeen = 0;
    int   vsSeen = 0;
    for (int c = 0; c < 2 * TB_FRAME; c++) begin
      advance();
      if (prevHs === 1'b1 && vga_hs === 1'b0) begin
        hsLen = 0;
        total++;
        if (xpos !== 10'(TB_HA + TB_HFP + TB_PIPE)) begin
          bad++;
          $display("[TB] FAIL hs_start got=%0d exp=%0d", xpos, TB_HA + TB_HFP + TB_PIPE);
        end
      end
      if (vga_hs === 1'b0 && hsLen >= 0) hsLen++;
      if (prevHs === 1'b0 && vga_hs === 1'b1 && hsLen >= 0) begin
        hsSeen++;
        total++;
        if (hsLen != TB_HS) begin
          bad++;
          $display("[TB] FAIL hs_width got=%0d exp=%0d", hsLen, TB_HS);
        end
      end
      if (prevVs === 1'b1 && vga_vs === 1'b0) begin
        vsLen = 0;
        total++;
        if (xpos !== 10'(TB_PIPE) || ypos !== 10'(TB_VA + TB_VFP)) begin
          bad++;
          $display("[TB] FAIL vs_start got=(%0d,%0d) exp=(%0d,%0d)", xpos, ypos, TB_PIPE, TB_VA + TB_VFP);
        end
      end
      if (vga_vs === 1'b0 && vsLen >= 0) vsLen++;
      if (prevVs === 1'b0 && vga_vs === 1'b1 && vsLen >= 0) begin
        vsSeen++;
        total++;
        if (vsLen != TB_VS * TB_HT) begin
          bad++;
          $display("[TB] FAIL vs_width got=%0d exp=%0d", vsLen, TB_VS * TB_HT);
        end
      end
      prevHs = vga_hs;
      prevVs = vga_vs;
    end
    total++;
    if (hsSeen < TB_VT || vsSeen < 1) begin
      bad++;
      $display("[TB] FAIL sync_seen got hs=%0d vs=%0d exp hs>=%0d vs>=1", hsSeen, vsSeen, TB_VT);
    end
  endtask

  task automatic test_midreset();
    int guard = 0;
    while (!(mx == 30 && my == 10) && guard < 2 * TB_FRAME) begin
      advance();
      guard++;
    end
    total++;
    if (xpos !== 10'd30 || ypos !== 10'd10 || frame_count === 16'd0) begin
      bad++;
      $display("[TB] FAIL midreset_reach got=(%0d,%0d) cnt=%0d exp=(30,10) cnt>0", xpos, ypos, frame_count);
    end
    Reset = 1'b1;
    advance();
    Reset = 1'b0;
    total++;
    if (xpos !== 10'd0 || ypos !== 10'd0 || frame_count !== 16'd0) begin
      bad++;
      $display("[TB] FAIL midreset_state got=(%0d,%0d) cnt=%0d exp=(0,0) cnt=0", xpos, ypos, frame_count);
    end
    for (int c = 0; c < TB_PIPE + 2; c++) begin
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== sbq[0]) begin
        bad++;
        $display("[TB] FAIL midreset_pins cyc=%0d got=%h exp=%h", c, {vga_r, vga_g, vga_b, vga_hs, vga_vs}, sbq[0]);
      end
      advance();
    end
  endtask

  task automatic test_reset_on_tick();
    int guard = 0;
    while (frame_tick !== 1'b1 && guard < 2 * TB_FRAME) begin
      advance();
      guard++;
    end
    total++;
    if (frame_tick !== 1'b1 || frame_count !== mCount) begin
      bad++;
      $display("[TB] FAIL tick_wait got tick=%b cnt=%0d exp tick=1 cnt=%0d", frame_tick, frame_count, mCount);
    end
    Reset = 1'b1;
    advance();
    Reset = 1'b0;
    advance();
    total++;
    if (frame_count !== 16'd0 || frame_tick !== 1'b0 || xpos !== 10'd1) begin
      bad++;
      $display("[TB] FAIL reset_on_tick got cnt=%0d tick=%b x=%0d exp cnt=0 tick=0 x=1", frame_count, frame_tick, xpos);
    end
  endtask

  task automatic test_pattern();
    int guard = 0;
    red_in = 5'h0A;
    green_in = 6'h05;
    blue_in = 5'h11;
    while (!(mx == 0 && my == 2) && guard < 2 * TB_FRAME) begin
      advance();
      guard++;
    end
    test_pat = 1'b1;
    for (int c = 0; c < TB_HT; c++) begin
      advance();
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== sbq[0]) begin
        bad++;
        $display("[TB] FAIL pattern_pins at (%0d,%0d) got=%h exp=%h", mx, my,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs}, sbq[0]);
      end
`ifdef VGA_TEST_PATTERN_EN
      if (mx == TB_HA / 8 + 2 + TB_PIPE) begin
        total++;
        if ({vga_r, vga_g, vga_b} !== {5'h1F, 6'h3F, 5'h00}) begin
          bad++;
          $display("[TB] FAIL pattern_yellow got=%h exp=%h", {vga_r, vga_g, vga_b}, {5'h1F, 6'h3F, 5'h00});
        end
      end
`endif
    end
    test_pat = 1'b0;
    for (int c = 0; c < TB_HT; c++) begin
      advance();
      total++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs} !== sbq[0]) begin
        bad++;
        $display("[TB] FAIL game_restored at (%0d,%0d) got=%h exp=%h", mx, my,
                 {vga_r, vga_g, vga_b, vga_hs, vga_vs}, sbq[0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < TB_PIPE; i++) sbq.push_back(blankPins());
    test_reset();
    test_frame();
    test_colour();
    test_sync();
    test_midreset();
    test_reset_on_tick();
    test_pattern();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
